// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// decodes opcode into datapath controls, and counts retired instructions.
module mc_control #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state_out
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t state, state_nxt;
    logic [COUNT_W-1:0] count_q;

    // The branch decision is made in the datapath; this block only needs to
    // expose pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (instr_done)
                count_q <= count_q + COUNT_W'(1);
        end
    end

    assign instr_count = count_q;
    assign state_out   = state;

    // Gating everything on rst_n keeps FETCH's Moore outputs quiet during reset.
    always_comb begin
        state_nxt     = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_nxt = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_nxt = MEM_ADDR;
                        OP_R:         state_nxt = EXECUTE;
                        OP_BEQ:       state_nxt = BRANCH;
                        OP_J:         state_nxt = JUMP;
                        OP_ADDI:      state_nxt = ADDI_EXEC;
                        default: begin
                            state_nxt  = FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LW)      state_nxt = MEM_READ;
                    else if (opcode == OP_SW) state_nxt = MEM_WRITE;
                    else                      state_nxt = FETCH;
                end
                MEM_READ: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b1;
                    state_nxt = mem_ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    state_nxt  = mem_ready ? FETCH : MEM_WRITE;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_nxt = ALU_WB;
                end
                ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = ADDI_WB;
                end
                ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state and full control-vector checks
// against the state table, plus counter wrap on a 4-bit instance.
module tb_mc_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst_n, zero, mem_ready;
    logic [5:0] opcode;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic [15:0] instr_count;
    logic [3:0] state_out;

    logic pw4, pwc4, iod4, mr4, mw4, irw4, m2r4, rd4, rw4, sa4, done4, ill4;
    logic [1:0] sb4, ps4, aop4;
    logic [3:0] count4, state4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_control #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count), .state_out(state_out)
    );

    mc_control #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pw4), .pc_write_cond(pwc4), .i_or_d(iod4),
        .mem_read(mr4), .mem_write(mw4), .ir_write(irw4),
        .mem_to_reg(m2r4), .reg_dst(rd4), .reg_write(rw4),
        .alu_src_a(sa4), .alu_src_b(sb4), .pc_source(ps4),
        .alu_op(aop4), .instr_done(done4), .illegal_op(ill4),
        .instr_count(count4), .state_out(state4)
    );

    logic [17:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, instr_done, illegal_op};

    // Expected control vector straight from the state table, same bit order as ctl.
    function automatic logic [17:0] exp_ctl(int s, logic rdy, logic ill);
        logic [17:0] c;
        c = '0;
        case (s)
            0:  begin c[14] = 1'b1; c[7:6] = 2'b01; c[12] = rdy; c[17] = rdy; end
            1:  begin c[7:6] = 2'b11; c[0] = ill; end
            2:  begin c[8] = 1'b1; c[7:6] = 2'b10; end
            3:  begin c[14] = 1'b1; c[15] = 1'b1; end
            4:  begin c[9] = 1'b1; c[11] = 1'b1; c[1] = 1'b1; end
            5:  begin c[13] = 1'b1; c[15] = 1'b1; c[1] = rdy; end
            6:  begin c[8] = 1'b1; c[3:2] = 2'b10; end
            7:  begin c[9] = 1'b1; c[10] = 1'b1; c[1] = 1'b1; end
            8:  begin c[8] = 1'b1; c[3:2] = 2'b01; c[16] = 1'b1; c[5:4] = 2'b01; c[1] = 1'b1; end
            9:  begin c[17] = 1'b1; c[5:4] = 2'b10; c[1] = 1'b1; end
            10: begin c[8] = 1'b1; c[7:6] = 2'b10; end
            11: begin c[9] = 1'b1; c[1] = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs, check current state and every control output, then clock.
    task automatic step(input string tag, input int s, input logic rdy,
                        input logic [5:0] op, input logic ill = 1'b0);
        mem_ready = rdy;
        opcode    = op;
        #1;
        chk({tag, ".state"}, 32'(state_out), 32'(s));
        chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl(s, rdy, ill)));
        adv();
    endtask

    initial begin
        rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        #12;
        chk("rst.state", 32'(state_out), 32'd0);
        chk("rst.ctl", 32'(ctl), 32'd0);
        chk("rst.count", 32'(instr_count), 32'd0);
        adv();
        rst_n = 1'b1;

        // R-type interrupted by reset in EXECUTE
        step("r0.f", 0, 1'b1, OP_R);
        step("r0.d", 1, 1'b1, OP_R);
        chk("r0.exec", 32'(state_out), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst.ctl", 32'(ctl), 32'd0);
        chk("midrst.state", 32'(state_out), 32'd0);
        adv();
        chk("midrst.hold", 32'(ctl), 32'd0);
        chk("midrst.count", 32'(instr_count), 32'd0);
        rst_n = 1'b1;

        // R-type then addi; mem_ready toggled in non-memory states to show it is ignored
        step("r1.f", 0, 1'b1, OP_R);
        step("r1.d", 1, 1'b0, OP_R);
        step("r1.ex", 6, 1'b0, OP_R);
        step("r1.wb", 7, 1'b1, OP_R);
        step("ai.f", 0, 1'b1, OP_ADDI);
        step("ai.d", 1, 1'b1, OP_ADDI);
        step("ai.ex", 10, 1'b0, OP_ADDI);
        step("ai.wb", 11, 1'b1, OP_ADDI);
        chk("ai.count", 32'(instr_count), 32'd2);

        // lw with three stall cycles in MEM_READ
        step("lw.f", 0, 1'b1, OP_LW);
        step("lw.d", 1, 1'b1, OP_LW);
        step("lw.ma", 2, 1'b1, OP_LW);
        step("lw.mr0", 3, 1'b0, OP_LW);
        step("lw.mr1", 3, 1'b0, OP_LW);
        step("lw.mr2", 3, 1'b0, OP_LW);
        chk("lw.stallcount", 32'(instr_count), 32'd2);
        step("lw.mr3", 3, 1'b1, OP_LW);
        step("lw.wb", 4, 1'b1, OP_LW);
        chk("lw.count", 32'(instr_count), 32'd3);

        // sw, beq, j back to back
        step("sw.f", 0, 1'b1, OP_SW);
        step("sw.d", 1, 1'b1, OP_SW);
        step("sw.ma", 2, 1'b1, OP_SW);
        step("sw.mw", 5, 1'b1, OP_SW);
        step("beq.f", 0, 1'b1, OP_BEQ);
        step("beq.d", 1, 1'b1, OP_BEQ);
        step("beq.br", 8, 1'b1, OP_BEQ);
        step("j.f", 0, 1'b1, OP_J);
        step("j.d", 1, 1'b1, OP_J);
        step("j.jmp", 9, 1'b1, OP_J);
        chk("sbj.count", 32'(instr_count), 32'd6);

        // sw with stalls in FETCH and MEM_WRITE
        step("sws.f0", 0, 1'b0, OP_SW);
        step("sws.f1", 0, 1'b1, OP_SW);
        step("sws.d", 1, 1'b1, OP_SW);
        step("sws.ma", 2, 1'b1, OP_SW);
        step("sws.mw0", 5, 1'b0, OP_SW);
        step("sws.mw1", 5, 1'b1, OP_SW);
        chk("sws.count", 32'(instr_count), 32'd7);

        // illegal opcodes
        step("ill.f", 0, 1'b1, 6'b111111);
        step("ill.d", 1, 1'b1, 6'b111111, 1'b1);
        step("ill2.f", 0, 1'b1, 6'b000011);
        step("ill2.d", 1, 1'b1, 6'b000011, 1'b1);
        chk("ill.state", 32'(state_out), 32'd0);
        chk("ill.count", 32'(instr_count), 32'd7);

        // 17 R-types after reset; 4-bit counter wraps 15 -> 0 -> 1
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step("wr.f", 0, 1'b1, OP_R);
            step("wr.d", 1, 1'b1, OP_R);
            step("wr.ex", 6, 1'b1, OP_R);
            step("wr.wb", 7, 1'b1, OP_R);
            if (i == 15) chk("wrap.c15", 32'(count4), 32'd15);
            if (i == 16) chk("wrap.c0", 32'(count4), 32'd0);
        end
        chk("wrap.c1", 32'(count4), 32'd1);
        chk("wrap.c16b", 32'(instr_count), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
